wave_req_arb: RTL and testbench



---
 rtl/wave_req_arb.sv | 192 +++++++++++++++++++
 tb/tb_wave_req_arb.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wave_req_arb.sv
// wave_req_arb
// Round-robin arbiter between the wave-select stage and the waveform
// playback memory. Rising edges on the per-wave request lines are latched
// as pending bits, and pending waves are handed out one at a time as single
// read requests over a req/ack handshake that gives up after TIMEOUT cycles.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   Waves_req  per-wave request levels (only [N_WAVE-1:0] used)
//   cfg_wren   register write strobe
//   cfg_addr   register address ([1:0] decoded)
//   cfg_data   register write data
//   rd_req     read request to playback memory
//   rd_idx     wave index of the current request
//   rd_ack     memory accepts the current request
//   busy       arbiter is not idle
//   pend       pending request bits
//   ovf_flags  sticky per-wave overflow flags
//   tmo_flag   sticky timeout flag
//
// Register map (write only):
//   0  enable mask (reset all ones); a 0 bit drops that wave's pending
//      request unless that wave is the one currently being requested
//   1  write-1-to-clear ovf_flags
//   2  bit 0 = 1 clears tmo_flag
//   3  no effect

module wave_req_arb #(
  parameter int N_WAVE  = 8,
  parameter int IDX_W   = 3,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       Waves_req,
  input  logic              cfg_wren,
  input  logic [7:0]        cfg_addr,
  input  logic [7:0]        cfg_data,
  output logic              rd_req,
  output logic [IDX_W-1:0]  rd_idx,
  input  logic              rd_ack,
  output logic              busy,
  output logic [N_WAVE-1:0] pend,
  output logic [N_WAVE-1:0] ovf_flags,
  output logic              tmo_flag
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   rd_idx_nxt;
  logic [IDX_W-1:0]   last_gnt, last_gnt_nxt;
  logic [7:0]         tmo_cnt, tmo_cnt_nxt;
  logic               tmo_set;

  logic [N_WAVE-1:0]  req_d;
  logic [N_WAVE-1:0]  en_mask;
  logic [N_WAVE-1:0]  rise;
  logic [N_WAVE-1:0]  cand;
  logic [N_WAVE-1:0]  granted;
  logic [N_WAVE-1:0]  grant_clr;
  logic [N_WAVE-1:0]  mask_clr;
  logic [N_WAVE-1:0]  clr_vec;
  logic [N_WAVE-1:0]  cfg_vec;

  logic               wr_mask, wr_ovf, wr_tmo;
  logic               rr_found;
  logic [IDX_W-1:0]   rr_idx;

  logic               unused_bits;

  assign unused_bits = ^{cfg_addr[7:2], Waves_req[31:N_WAVE]};

  assign cfg_vec = N_WAVE'(cfg_data);
  assign wr_mask = cfg_wren && (cfg_addr[1:0] == 2'd0);
  assign wr_ovf  = cfg_wren && (cfg_addr[1:0] == 2'd1);
  assign wr_tmo  = cfg_wren && (cfg_addr[1:0] == 2'd2);

  assign rd_req = (state == REQ);
  assign busy   = (state != IDLE);

  assign rise = Waves_req[N_WAVE-1:0] & ~req_d & en_mask;
  assign cand = pend & en_mask;

  // The wave being requested right now is protected from mask clears so a
  // grant in flight is never pulled out from under the memory.
  assign granted  = rd_req ? (N_WAVE'(1) << rd_idx) : '0;
  assign mask_clr = wr_mask ? (~cfg_vec & ~granted) : '0;
  assign clr_vec  = grant_clr | mask_clr;

  // Round-robin search: start just above the last granted wave and wrap, so
  // the most recently served wave has the lowest priority.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int k = 0; k < N_WAVE; k++) begin
      if (!rr_found && cand[IDX_W'((int'(last_gnt) + 1 + k) % N_WAVE)]) begin
        rr_found = 1'b1;
        rr_idx   = IDX_W'((int'(last_gnt) + 1 + k) % N_WAVE);
      end
    end
  end

  // Next-state logic. A grant ends either on ack (then one HOLD cycle so
  // rd_req always drops between requests) or on timeout (straight to IDLE).
  // Either way the wave's pending bit is released and it becomes the new
  // round-robin reference.
  always_comb begin
    state_nxt    = state;
    rd_idx_nxt   = rd_idx;
    tmo_cnt_nxt  = tmo_cnt;
    last_gnt_nxt = last_gnt;
    grant_clr    = '0;
    tmo_set      = 1'b0;
    unique case (state)
      IDLE: begin
        if (rr_found) begin
          rd_idx_nxt  = rr_idx;
          tmo_cnt_nxt = '0;
          state_nxt   = REQ;
        end
      end
      REQ: begin
        if (rd_ack) begin
          grant_clr[rd_idx] = 1'b1;
          last_gnt_nxt      = rd_idx;
          state_nxt         = HOLD;
        end else if (tmo_cnt == 8'(TIMEOUT - 1)) begin
          grant_clr[rd_idx] = 1'b1;
          tmo_set           = 1'b1;
          last_gnt_nxt      = rd_idx;
          state_nxt         = IDLE;
        end else begin
          tmo_cnt_nxt = tmo_cnt + 8'd1;
        end
      end
      HOLD: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // FSM state and grant bookkeeping. Reset to IDLE drops rd_req at once
  // because rd_req is decoded straight from the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rd_idx   <= '0;
      tmo_cnt  <= '0;
      last_gnt <= IDX_W'(N_WAVE - 1);
    end else begin
      state    <= state_nxt;
      rd_idx   <= rd_idx_nxt;
      tmo_cnt  <= tmo_cnt_nxt;
      last_gnt <= last_gnt_nxt;
    end
  end

  // Pending bits, flags and config. A new edge wins over a clear in the same
  // cycle, and only counts as an overflow when it lands on a pending bit
  // that is staying set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_d     <= '0;
      en_mask   <= '1;
      pend      <= '0;
      ovf_flags <= '0;
      tmo_flag  <= 1'b0;
    end else begin
      req_d     <= Waves_req[N_WAVE-1:0];
      pend      <= (pend & ~clr_vec) | rise;
      ovf_flags <= (ovf_flags & ~(wr_ovf ? cfg_vec : '0)) | (rise & pend & ~clr_vec);
      if (wr_mask) begin
        en_mask <= cfg_vec;
      end
      if (tmo_set) begin
        tmo_flag <= 1'b1;
      end else if (wr_tmo && cfg_data[0]) begin
        tmo_flag <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wave_req_arb.sv
// tb_wave_req_arb
// Directed bench for wave_req_arb (TIMEOUT=4). A behavioural model of the
// arbiter is updated every rising edge; a compare process checks all DUT
// outputs against it on every falling edge. Hand-computed literal checks
// in the stimulus sequence pin the model to known-good values.

module tb_wave_req_arb;

  localparam int NW  = 8;
  localparam int TMO = 4;

  logic        clk;
  logic        rst;
  logic [31:0] Waves_req;
  logic        cfg_wren;
  logic [7:0]  cfg_addr;
  logic [7:0]  cfg_data;
  logic        rd_req;
  logic [2:0]  rd_idx;
  logic        rd_ack;
  logic        busy;
  logic [7:0]  pend;
  logic [7:0]  ovf_flags;
  logic        tmo_flag;

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  wave_req_arb #(
    .N_WAVE (NW),
    .IDX_W  (3),
    .TIMEOUT(TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .Waves_req(Waves_req),
    .cfg_wren (cfg_wren),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .rd_req   (rd_req),
    .rd_idx   (rd_idx),
    .rd_ack   (rd_ack),
    .busy     (busy),
    .pend     (pend),
    .ovf_flags(ovf_flags),
    .tmo_flag (tmo_flag)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: per-wave bit arrays, a phase (0 idle, 1 requesting,
  // 2 hold) and the number of cycles the current request has been visible.
  bit m_pend[NW];
  bit m_ovf[NW];
  bit m_mask[NW];
  bit m_reqd[NW];
  bit m_tmo;
  int m_phase;
  int m_idx;
  int m_last;
  int m_age;
  bit m_clr[NW];
  bit m_rise[NW];
  bit m_gnt[NW];
  bit m_found;
  bit m_tmo_hit;
  int m_j;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NW; i++) begin
        m_pend[i] = 1'b0;
        m_ovf[i]  = 1'b0;
        m_mask[i] = 1'b1;
        m_reqd[i] = 1'b0;
      end
      m_tmo   = 1'b0;
      m_phase = 0;
      m_idx   = 0;
      m_last  = NW - 1;
      m_age   = 0;
    end else begin
      m_tmo_hit = 1'b0;
      for (int i = 0; i < NW; i++) begin
        m_rise[i] = Waves_req[i] && !m_reqd[i] && m_mask[i];
        m_clr[i]  = 1'b0;
        m_gnt[i]  = (m_phase == 1) && (m_idx == i);
      end
      case (m_phase)
        0: begin
          m_found = 1'b0;
          for (int k = 1; k <= NW; k++) begin
            m_j = (m_last + k) % NW;
            if (!m_found && m_pend[m_j] && m_mask[m_j]) begin
              m_found = 1'b1;
              m_idx   = m_j;
            end
          end
          if (m_found) begin
            m_phase = 1;
            m_age   = 1;
          end
        end
        1: begin
          if (rd_ack) begin
            m_clr[m_idx] = 1'b1;
            m_last       = m_idx;
            m_phase      = 2;
          end else if (m_age == TMO) begin
            m_clr[m_idx] = 1'b1;
            m_tmo_hit    = 1'b1;
            m_last       = m_idx;
            m_phase      = 0;
          end else begin
            m_age = m_age + 1;
          end
        end
        default: m_phase = 0;
      endcase
      if (cfg_wren && cfg_addr[1:0] == 2'd0) begin
        for (int i = 0; i < NW; i++) begin
          if (!cfg_data[i] && !m_gnt[i]) m_clr[i] = 1'b1;
        end
      end
      if (cfg_wren && cfg_addr[1:0] == 2'd1) begin
        for (int i = 0; i < NW; i++) begin
          if (cfg_data[i]) m_ovf[i] = 1'b0;
        end
      end
      for (int i = 0; i < NW; i++) begin
        if (m_rise[i]) begin
          if (m_pend[i] && !m_clr[i]) m_ovf[i] = 1'b1;
          m_pend[i] = 1'b1;
        end else if (m_clr[i]) begin
          m_pend[i] = 1'b0;
        end
      end
      if (m_tmo_hit) m_tmo = 1'b1;
      else if (cfg_wren && cfg_addr[1:0] == 2'd2 && cfg_data[0]) m_tmo = 1'b0;
      if (cfg_wren && cfg_addr[1:0] == 2'd0) begin
        for (int i = 0; i < NW; i++) m_mask[i] = cfg_data[i];
      end
      for (int i = 0; i < NW; i++) m_reqd[i] = Waves_req[i];
    end
  end

  function automatic logic [7:0] pack8(input bit v[NW]);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < NW; i++) r[i] = v[i];
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    if (check_en && !rst) begin
      checkOutput("rd_req", 32'(rd_req), 32'(m_phase == 1));
      checkOutput("busy", 32'(busy), 32'(m_phase != 0));
      if (m_phase == 1) checkOutput("rd_idx", 32'(rd_idx), 32'(m_idx));
      checkOutput("pend", 32'(pend), 32'(pack8(m_pend)));
      checkOutput("ovf_flags", 32'(ovf_flags), 32'(pack8(m_ovf)));
      checkOutput("tmo_flag", 32'(tmo_flag), 32'(m_tmo));
    end
  end

  task automatic applyStimulus(input logic [31:0] w, input logic ack, input logic wren,
                               input logic [7:0] addr, input logic [7:0] data);
    @(negedge clk);
    Waves_req = w;
    rd_ack    = ack;
    cfg_wren  = wren;
    cfg_addr  = addr;
    cfg_data  = data;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(32'h0, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic resetDut();
    @(negedge clk);
    #2 rst = 1'b1;
    Waves_req = '0;
    rd_ack    = 1'b0;
    cfg_wren  = 1'b0;
    cfg_addr  = '0;
    cfg_data  = '0;
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "[TB] watchdog expired");
  end

  int  hi_cnt;
  bit  dropped;

  initial begin
    rst       = 1'b0;
    Waves_req = '0;
    rd_ack    = 1'b0;
    cfg_wren  = 1'b0;
    cfg_addr  = '0;
    cfg_data  = '0;
    #1 rst = 1'b1;
    @(negedge clk);
    #1 rst = 1'b0;

    $display("[TB] reset values");
    checkOutput("rst_rd_req", 32'(rd_req), 32'h0);
    checkOutput("rst_rd_idx", 32'(rd_idx), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_pend", 32'(pend), 32'h0);
    checkOutput("rst_ovf", 32'(ovf_flags), 32'h0);
    checkOutput("rst_tmo", 32'(tmo_flag), 32'h0);
    check_en = 1'b1;

    $display("[TB] single request on wave 2");
    applyStimulus(32'hFF00_0004, 1'b0, 1'b0, 8'h00, 8'h00);
    applyStimulus(32'h0, 1'b0, 1'b0, 8'h00, 8'h00);
    checkOutput("t1_pend", 32'(pend), 32'h04);
    checkOutput("t1_noreq", 32'(rd_req), 32'h0);
    applyStimulus(32'h0, 1'b0, 1'b0, 8'h00, 8'h00);
    checkOutput("t1_req", 32'(rd_req), 32'h1);
    checkOutput("t1_idx", 32'(rd_idx), 32'h2);
    applyStimulus(32'h0, 1'b1, 1'b0, 8'h00, 8'h00);
    applyStimulus(32'h0, 1'b0, 1'b0, 8'h00, 8'h00);
    checkOutput("t1_drop", 32'(rd_req), 32'h0);
    checkOutput("t1_pend0", 32'(pend), 32'h0);
    checkOutput("t1_hold", 32'(busy), 32'h1);
    applyStimulus(32'h0, 1'b0, 1'b0, 8'h00, 8'h00);
    checkOutput("t1_idle", 32'(busy), 32'h0);
    idleCycles(2);

    $display("[TB] round robin 0,3,7 then wrap to 0");
    resetDut();
    applyStimulus(32'h89, 1'b1, 1'b0, 8'h00, 8'h00);
    applyStimulus(32'h0, 1'b1, 1'b0, 8'h00, 8'h00);
    checkOutput("t2_pend", 32'(pend), 32'h89);
    applyStimulus(32'h0, 1'b1, 1'b0, 8'h00, 8'h00);
    checkOutput("t2_g0_req", 32'(rd_req), 32'h1);
    checkOutput("t2_g0_idx", 32'(rd_idx), 32'h0);
    applyStimulus(32'h0, 1'b1, 1'b0, 8'h00, 8'h00);
    applyStimulus(32'h0, 1'b1, 1'b0, 8'h00, 8'h00);
    applyStimulus(32'h1, 1'b1, 1'b0, 8'h00, 8'h00);
    checkOutput("t2_g3_req", 32'(rd_req), 32'h1);
    checkOutput("t2_g3_idx", 32'(rd_idx), 32'h3);
    applyStimulus(32'h0, 1'b1, 1'b0, 8'h00, 8'h00);
    applyStimulus(32'h0, 1'b1, 1'b0, 8'h00, 8'h00);
    applyStimulus(32'h0, 1'b1, 1'b0, 8'h00, 8'h00);
    checkOutput("t2_g7_req", 32'(rd_req), 32'h1);
    checkOutput("t2_g7_idx", 32'(rd_idx), 32'h7);
    applyStimulus(32'h0, 1'b1, 1'b0, 8'h00, 8'h00);
    applyStimulus(32'h0, 1'b1, 1'b0, 8'h00, 8'h00);
    applyStimulus(32'h0, 1'b1, 1'b0, 8'h00, 8'h00);
    checkOutput("t2_wrap_req", 32'(rd_req), 32'h1);
    checkOutput("t2_wrap_idx", 32'(rd_idx), 32'h0);
    applyStimulus(32'h0, 1'b1, 1'b0, 8'h00, 8'h00);
    idleCycles(3);

    $display("[TB] overflow on wave 5 and clear");
    applyStimulus(32'h20, 1'b0, 1'b0, 8'h00, 8'h00);
    applyStimulus(32'h0, 1'b0, 1'b0, 8'h00, 8'h00);
    checkOutput("t3_pend", 32'(pend), 32'h20);
    applyStimulus(32'h20, 1'b0, 1'b0, 8'h00, 8'h00);
    checkOutput("t3_idx", 32'(rd_idx), 32'h5);
    applyStimulus(32'h0, 1'b1, 1'b0, 8'h00, 8'h00);
    checkOutput("t3_ovf", 32'(ovf_flags), 32'h20);
    applyStimulus(32'h0, 1'b0, 1'b0, 8'h00, 8'h00);
    checkOutput("t3_pend0", 32'(pend), 32'h0);
    applyStimulus(32'h0, 1'b0, 1'b1, 8'h01, 8'h20);
    applyStimulus(32'h0, 1'b0, 1'b0, 8'h00, 8'h00);
    checkOutput("t3_ovf_clr", 32'(ovf_flags), 32'h0);
    idleCycles(2);

    $display("[TB] timeout on wave 1");
    applyStimulus(32'h2, 1'b0, 1'b0, 8'h00, 8'h00);
    applyStimulus(32'h0, 1'b0, 1'b0, 8'h00, 8'h00);
    hi_cnt  = 0;
    dropped = 1'b0;
    for (int i = 0; i < 20 && !dropped; i++) begin
      applyStimulus(32'h0, 1'b0, 1'b0, 8'h00, 8'h00);
      if (rd_req) begin
        if (hi_cnt == 0) checkOutput("t4_idx", 32'(rd_idx), 32'h1);
        hi_cnt++;
      end else if (hi_cnt > 0) begin
        dropped = 1'b1;
      end
    end
    checkOutput("t4_dropped", 32'(dropped), 32'h1);
    checkOutput("t4_high_cycles", 32'(hi_cnt), 32'(TMO));
    checkOutput("t4_tmo", 32'(tmo_flag), 32'h1);
    checkOutput("t4_pend0", 32'(pend), 32'h0);
    applyStimulus(32'h0, 1'b0, 1'b1, 8'h02, 8'h01);
    applyStimulus(32'h0, 1'b0, 1'b0, 8'h00, 8'h00);
    checkOutput("t4_tmo_clr", 32'(tmo_flag), 32'h0);
    idleCycles(2);

    $display("[TB] mask and rise coinciding with ack");
    applyStimulus(32'h0, 1'b0, 1'b1, 8'h00, 8'hFE);
    applyStimulus(32'h1, 1'b0, 1'b0, 8'h00, 8'h00);
    applyStimulus(32'h0, 1'b0, 1'b0, 8'h00, 8'h00);
    applyStimulus(32'h0, 1'b0, 1'b0, 8'h00, 8'h00);
    checkOutput("t5_masked_pend", 32'(pend), 32'h0);
    checkOutput("t5_masked_req", 32'(rd_req), 32'h0);
    applyStimulus(32'h10, 1'b0, 1'b0, 8'h00, 8'h00);
    applyStimulus(32'h0, 1'b0, 1'b0, 8'h00, 8'h00);
    applyStimulus(32'h0, 1'b0, 1'b0, 8'h00, 8'h00);
    checkOutput("t5_idx", 32'(rd_idx), 32'h4);
    applyStimulus(32'h10, 1'b1, 1'b0, 8'h00, 8'h00);
    applyStimulus(32'h0, 1'b0, 1'b0, 8'h00, 8'h00);
    checkOutput("t5_pend_kept", 32'(pend), 32'h10);
    checkOutput("t5_no_ovf", 32'(ovf_flags), 32'h0);
    checkOutput("t5_drop", 32'(rd_req), 32'h0);
    applyStimulus(32'h0, 1'b0, 1'b0, 8'h00, 8'h00);
    applyStimulus(32'h0, 1'b0, 1'b0, 8'h00, 8'h00);
    checkOutput("t5_regrant_req", 32'(rd_req), 32'h1);
    checkOutput("t5_regrant_idx", 32'(rd_idx), 32'h4);
    applyStimulus(32'h0, 1'b1, 1'b0, 8'h00, 8'h00);
    idleCycles(3);

    $display("[TB] asynchronous reset mid-request");
    applyStimulus(32'h48, 1'b0, 1'b0, 8'h00, 8'h00);
    applyStimulus(32'h0, 1'b0, 1'b0, 8'h00, 8'h00);
    applyStimulus(32'h0, 1'b0, 1'b0, 8'h00, 8'h00);
    checkOutput("t6_req_before", 32'(rd_req), 32'h1);
    #2 rst = 1'b1;
    #1;
    checkOutput("t6_rst_req", 32'(rd_req), 32'h0);
    checkOutput("t6_rst_busy", 32'(busy), 32'h0);
    checkOutput("t6_rst_pend", 32'(pend), 32'h0);
    checkOutput("t6_rst_idx", 32'(rd_idx), 32'h0);
    @(negedge clk);
    #1 rst = 1'b0;
    applyStimulus(32'h81, 1'b0, 1'b0, 8'h00, 8'h00);
    applyStimulus(32'h0, 1'b0, 1'b0, 8'h00, 8'h00);
    applyStimulus(32'h0, 1'b0, 1'b0, 8'h00, 8'h00);
    checkOutput("t6_first_req", 32'(rd_req), 32'h1);
    checkOutput("t6_first_idx", 32'(rd_idx), 32'h0);
    applyStimulus(32'h0, 1'b1, 1'b0, 8'h00, 8'h00);
    idleCycles(8);

    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
